axi_rd_line_fetch: RTL and testbench
====================================

AXI_RD_LINE_FETCH -- requirements
Module: axi_rd_line_fetch

Interface
REQ-001 SHALL have parameter AxiNumWords, default 4, beats per line and maximum burst length (>=2).
REQ-002 SHALL have parameter AxiIdWidth, default 4, AXI ID width.
REQ-003 SHALL have parameter AxiUserWidth, default 64, user width per beat.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports listed below.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- req_valid_i  in  1  line fetch request
- req_ready_o  out  1  request accepted
- req_addr_i  in  64  line base address
- req_blen_i  in  clog2(AxiNumWords)  burst length, LEN-1
- req_id_i  in  AxiIdWidth  transaction ID
- rd_req_o  out  1  read request to the AXI shim
- rd_gnt_i  in  1  shim grant
- rd_addr_o  out  64  registered address
- rd_blen_o  out  clog2(AxiNumWords)  registered LEN-1
- rd_size_o  out  2  constant 2'b11
- rd_id_o  out  AxiIdWidth  registered ID
- rd_lock_o  out  1  constant 0
- rd_rdy_o  out  1  beat sink ready
- rd_valid_i  in  1  beat valid
- rd_last_i  in  1  last beat
- rd_data_i  in  64  beat data
- rd_user_i  in  AxiUserWidth  beat user
- rd_id_i  in  AxiIdWidth  beat ID
- line_valid_o  out  1  assembled line available
- line_ready_i  in  1  consumer accepts line
- line_data_o  out  AxiNumWords x 64  line data
- line_user_o  out  AxiNumWords x AxiUserWidth  line user bits
- line_err_o  out  1  beat-count or ID protocol error

Function
REQ-005 SHALL implement FSM IDLE, REQ, DATA, DONE; any illegal encoding SHALL go to IDLE.
REQ-006 IDLE: req_ready_o=1; on req_valid_i, register addr/blen/id, clear beat counter and error, go to REQ next cycle.
REQ-007 REQ: rd_req_o=1 with stable registered fields; on rd_gnt_i go to DATA next cycle; no timeout.
REQ-008 DATA: rd_rdy_o=1 every cycle; rd_rdy_o=0 in all other states.
REQ-009 Each rd_valid_i beat in DATA SHALL write word[cnt] of data and user buffers and increment cnt.
REQ-010 Counter SHALL be clog2(AxiNumWords)+1 bits and saturate; beats with cnt>blen SHALL be dropped and SHALL set error.
REQ-011 Beat with rd_last_i SHALL go to DONE next cycle; error SHALL be set if cnt at that beat != blen.
REQ-012 Beat at cnt==blen without rd_last_i SHALL set error; FSM stays in DATA until rd_last_i.
REQ-013 DONE: line_valid_o=1, outputs stable; on line_ready_i go to IDLE next cycle; req_ready_o=0 in DONE.
REQ-014 Line words not written by the current burst SHALL retain prior contents.
REQ-015 Minimum latency: request accept to line_valid_o = 3 cycles + beat count, with immediate grant and back-to-back beats.
REQ-016 line_err_o SHALL be valid only while line_valid_o=1 and SHALL be held 0 otherwise.

Reset
REQ-017 On rst_ni low: state IDLE, counter 0, error 0, registered addr/blen/id 0, line buffers 0.
REQ-018 Reset outputs: req_ready_o=1, rd_req_o=0, rd_rdy_o=0, line_valid_o=0, line_err_o=0.
REQ-019 Reset mid-burst SHALL abandon the transfer; beats arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-020 Macro AXI_RD_LINE_FETCH_ID_CHECK_EN defined: a DATA beat with rd_id_i != registered ID SHALL be dropped (no write, no count, no FSM transition even with rd_last_i) and SHALL set error.
REQ-021 Macro undefined: rd_id_i SHALL be ignored and every DATA beat processed per REQ-009..012.

Verification
REQ-022 AxiNumWords=4, req blen=3 addr 0x8000_0040 id 2, grant after 2 cycles, 4 beats 0x11..0x44 with last on 4th -> line_data_o={0x44,0x33,0x22,0x11}, line_err_o=0, line_valid_o in DONE.
REQ-023 blen=0 single beat 0xDEAD with last -> word0=0xDEAD, other words unchanged, line_err_o=0.
REQ-024 blen=3, rd_last_i on 2nd beat -> DONE after that beat, line_err_o=1.
REQ-025 blen=1, 3 beats with last on 3rd -> words 0..1 written, 3rd dropped, line_err_o=1.
REQ-026 With ID_CHECK_EN: mismatched-ID beat inserted mid-burst -> beat dropped, correct line assembled, line_err_o=1; without macro the beat is consumed.
REQ-027 Assert rst_ni during DATA after 2 beats, then drive beats -> rd_rdy_o=0, line_valid_o=0, state IDLE, req_ready_o=1.

Source files
------------

// File: rtl/axi_rd_line_fetch.sv
// Fetches one cache line via a single AXI read burst and assembles the beats into a line buffer.
// Optional macro AXI_RD_LINE_FETCH_ID_CHECK_EN drops (and flags) DATA beats whose ID differs from the request.
module axi_rd_line_fetch #(
  parameter  int AxiNumWords  = 4,
  parameter  int AxiIdWidth   = 4,
  parameter  int AxiUserWidth = 64,
  localparam int BlenW        = $clog2(AxiNumWords),
  localparam int CntW         = BlenW + 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [63:0]                          req_addr_i,
  input  logic [BlenW-1:0]                     req_blen_i,
  input  logic [AxiIdWidth-1:0]                req_id_i,
  output logic                                 rd_req_o,
  input  logic                                 rd_gnt_i,
  output logic [63:0]                          rd_addr_o,
  output logic [BlenW-1:0]                     rd_blen_o,
  output logic [1:0]                           rd_size_o,
  output logic [AxiIdWidth-1:0]                rd_id_o,
  output logic                                 rd_lock_o,
  output logic                                 rd_rdy_o,
  input  logic                                 rd_valid_i,
  input  logic                                 rd_last_i,
  input  logic [63:0]                          rd_data_i,
  input  logic [AxiUserWidth-1:0]              rd_user_i,
  input  logic [AxiIdWidth-1:0]                rd_id_i,
  output logic                                 line_valid_o,
  input  logic                                 line_ready_i,
  output logic [AxiNumWords*64-1:0]            line_data_o,
  output logic [AxiNumWords*AxiUserWidth-1:0]  line_user_o,
  output logic                                 line_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t                                   state;
  logic                                     req_ready_q, rd_req_q, rd_rdy_q, line_valid_q;
  logic [63:0]                              addr_q;
  logic [BlenW-1:0]                         blen_q;
  logic [AxiIdWidth-1:0]                    id_q;
  logic [CntW-1:0]                          cnt_q;
  logic                                     err_q;
  logic [AxiNumWords-1:0][63:0]             data_q;
  logic [AxiNumWords-1:0][AxiUserWidth-1:0] user_q;

  logic beat, id_ok, over, at_end, wr, set_err;

  assign beat = (state == DATA) && rd_valid_i;

`ifdef AXI_RD_LINE_FETCH_ID_CHECK_EN
  assign id_ok = (rd_id_i == id_q);
`else
  logic unused_rd_id;
  assign unused_rd_id = ^rd_id_i;
  assign id_ok        = 1'b1;
`endif

  assign over    = cnt_q > {1'b0, blen_q};
  assign at_end  = cnt_q == {1'b0, blen_q};
  assign wr      = beat && id_ok && !over && (cnt_q < CntW'(AxiNumWords));
  // A good beat is flagged whenever its last flag disagrees with reaching the programmed length.
  assign set_err = beat && (!id_ok || over || (rd_last_i != at_end));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      req_ready_q  <= 1'b1;
      rd_req_q     <= 1'b0;
      rd_rdy_q     <= 1'b0;
      line_valid_q <= 1'b0;
      addr_q       <= '0;
      blen_q       <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr_q      <= req_addr_i;
            blen_q      <= req_blen_i;
            id_q        <= req_id_i;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            state       <= REQ;
            req_ready_q <= 1'b0;
            rd_req_q    <= 1'b1;
          end
        end
        REQ: begin
          if (rd_gnt_i) begin
            state    <= DATA;
            rd_req_q <= 1'b0;
            rd_rdy_q <= 1'b1;
          end
        end
        DATA: begin
          if (set_err) err_q <= 1'b1;
          if (beat && id_ok) begin
            if (!over && cnt_q != '1) cnt_q <= cnt_q + CntW'(1);
            if (rd_last_i) begin
              state        <= DONE;
              rd_rdy_q     <= 1'b0;
              line_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (line_ready_i) begin
            state        <= IDLE;
            line_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          req_ready_q  <= 1'b1;
          rd_req_q     <= 1'b0;
          rd_rdy_q     <= 1'b0;
          line_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Line buffer: only words hit by the current burst change, the rest keep older data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      user_q <= '0;
    end else if (wr) begin
      data_q[cnt_q[BlenW-1:0]] <= rd_data_i;
      user_q[cnt_q[BlenW-1:0]] <= rd_user_i;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rd_req_o     = rd_req_q;
  assign rd_rdy_o     = rd_rdy_q;
  assign rd_addr_o    = addr_q;
  assign rd_blen_o    = blen_q;
  assign rd_id_o      = id_q;
  assign rd_size_o    = 2'b11;
  assign rd_lock_o    = 1'b0;
  assign line_valid_o = line_valid_q;
  assign line_data_o  = data_q;
  assign line_user_o  = user_q;
  assign line_err_o   = err_q & line_valid_q;

endmodule

// File: tb/tb_axi_rd_line_fetch.sv
// Self-checking bench for axi_rd_line_fetch: directed line cases plus randomized bursts against a transaction-level model.
module tb_axi_rd_line_fetch;
  localparam int N  = 4;
  localparam int IW = 4;
  localparam int UW = 64;
`ifdef AXI_RD_LINE_FETCH_ID_CHECK_EN
  localparam bit IdCheck = 1'b1;
`else
  localparam bit IdCheck = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [63:0]     req_addr_i = '0;
  logic [1:0]      req_blen_i = '0;
  logic [IW-1:0]   req_id_i = '0;
  logic            rd_req_o;
  logic            rd_gnt_i = 1'b0;
  logic [63:0]     rd_addr_o;
  logic [1:0]      rd_blen_o;
  logic [1:0]      rd_size_o;
  logic [IW-1:0]   rd_id_o;
  logic            rd_lock_o;
  logic            rd_rdy_o;
  logic            rd_valid_i = 1'b0;
  logic            rd_last_i = 1'b0;
  logic [63:0]     rd_data_i = '0;
  logic [UW-1:0]   rd_user_i = '0;
  logic [IW-1:0]   rd_id_i = '0;
  logic            line_valid_o;
  logic            line_ready_i = 1'b0;
  logic [N*64-1:0] line_data_o;
  logic [N*UW-1:0] line_user_o;
  logic            line_err_o;

  axi_rd_line_fetch #(.AxiNumWords(N), .AxiIdWidth(IW), .AxiUserWidth(UW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_blen_i(req_blen_i), .req_id_i(req_id_i),
    .rd_req_o(rd_req_o), .rd_gnt_i(rd_gnt_i), .rd_addr_o(rd_addr_o), .rd_blen_o(rd_blen_o),
    .rd_size_o(rd_size_o), .rd_id_o(rd_id_o), .rd_lock_o(rd_lock_o), .rd_rdy_o(rd_rdy_o),
    .rd_valid_i(rd_valid_i), .rd_last_i(rd_last_i), .rd_data_i(rd_data_i),
    .rd_user_i(rd_user_i), .rd_id_i(rd_id_i),
    .line_valid_o(line_valid_o), .line_ready_i(line_ready_i), .line_data_o(line_data_o),
    .line_user_o(line_user_o), .line_err_o(line_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Transaction model state: persistent line contents and the expectation for the current line.
  logic [63:0]     m_data [N];
  logic [UW-1:0]   m_user [N];
  logic [N*64-1:0] exp_data = '0;
  logic [N*UW-1:0] exp_user = '0;
  logic            exp_err = 1'b0;
  logic [63:0]     exp_addr = '0;
  logic [1:0]      exp_blen = '0;
  logic [IW-1:0]   exp_id = '0;

  logic [63:0]   b_data [$];
  logic [UW-1:0] b_user [$];
  logic [IW-1:0] b_id   [$];
  bit            b_last [$];

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0:       return req_ready_o;
      1:       return rd_req_o;
      2:       return rd_rdy_o;
      default: return line_valid_o;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input string name);
    int k = 0;
    while (!sig(sel) && k < 200) begin
      tick();
      k++;
    end
    if (!sig(sel)) begin
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected assertion within 200 cycles", name);
    end
  endtask

  task automatic model_reset;
    for (int i = 0; i < N; i++) begin
      m_data[i] = '0;
      m_user[i] = '0;
    end
  endtask

  // Walks the beat list the way the line fetch is defined to treat it and derives the finished line.
  task automatic model_apply(input int blen, input logic [IW-1:0] id);
    int cnt = 0;
    bit err = 1'b0;
    for (int i = 0; i < b_data.size(); i++) begin
      if (IdCheck && b_id[i] != id) begin
        err = 1'b1;
        continue;
      end
      if (cnt <= blen) begin
        m_data[cnt] = b_data[i];
        m_user[cnt] = b_user[i];
      end else begin
        err = 1'b1;
      end
      if (b_last[i]) begin
        if (cnt != blen) err = 1'b1;
        break;
      end
      if (cnt == blen) err = 1'b1;
      cnt++;
    end
    exp_err = err;
    for (int i = 0; i < N; i++) begin
      exp_data[i*64 +: 64] = m_data[i];
      exp_user[i*UW +: UW] = m_user[i];
    end
  endtask

  task automatic clear_beats;
    b_data.delete(); b_user.delete(); b_id.delete(); b_last.delete();
  endtask

  task automatic push_beat(input logic [63:0] d, input logic [UW-1:0] u, input logic [IW-1:0] id, input bit last);
    b_data.push_back(d); b_user.push_back(u); b_id.push_back(id); b_last.push_back(last);
  endtask

  task automatic start_req(input logic [63:0] addr, input int blen, input logic [IW-1:0] id, input int gnt_dly);
    exp_addr    = addr;
    exp_blen    = 2'(blen);
    exp_id      = id;
    req_addr_i  = addr;
    req_blen_i  = 2'(blen);
    req_id_i    = id;
    req_valid_i = 1'b1;
    wait_sig(0, "req_ready");
    tick();
    req_valid_i = 1'b0;
    wait_sig(1, "rd_req");
    repeat (gnt_dly) tick();
    rd_gnt_i = 1'b1;
    tick();
    rd_gnt_i = 1'b0;
  endtask

  task automatic send_beat(input int i, input bit gaps);
    if (gaps && $urandom_range(0, 2) == 0) tick();
    rd_valid_i = 1'b1;
    rd_data_i  = b_data[i];
    rd_user_i  = b_user[i];
    rd_id_i    = b_id[i];
    rd_last_i  = b_last[i];
    tick();
    rd_valid_i = 1'b0;
    rd_last_i  = 1'b0;
  endtask

  task automatic run_burst(input logic [63:0] addr, input int blen, input logic [IW-1:0] id,
                           input int gnt_dly, input bit gaps);
    model_apply(blen, id);
    start_req(addr, blen, id, gnt_dly);
    wait_sig(2, "rd_rdy");
    for (int i = 0; i < b_data.size(); i++) send_beat(i, gaps);
    wait_sig(3, "line_valid");
  endtask

  task automatic consume(input int hold);
    repeat (hold) tick();
    line_ready_i = 1'b1;
    tick();
    line_ready_i = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    chk("reset_req_ready", req_ready_o, 1'b1);
    chk("reset_rd_req", rd_req_o, 1'b0);
    chk("reset_rd_rdy", rd_rdy_o, 1'b0);
    chk("reset_line_valid", line_valid_o, 1'b0);
    chk("reset_line_err", line_err_o, 1'b0);
    chk("reset_line_data", line_data_o, '0);

    fork
      forever begin
        @(negedge clk_i);
        if (rst_ni) begin
          chk("const_size_lock", {rd_size_o, rd_lock_o}, 3'b110);
          if (line_valid_o) begin
            chk("line_data", line_data_o, exp_data);
            chk("line_user", line_user_o, exp_user);
            chk("line_err", line_err_o, exp_err);
          end else begin
            chk("line_err_idle", line_err_o, 1'b0);
          end
          if (rd_req_o) chk("rd_fields", {rd_addr_o, rd_blen_o, rd_id_o}, {exp_addr, exp_blen, exp_id});
        end
      end
    join_none

    // Full 4-beat line with delayed grant.
    clear_beats();
    push_beat(64'h11, 64'h1, 4'd2, 0); push_beat(64'h22, 64'h2, 4'd2, 0);
    push_beat(64'h33, 64'h3, 4'd2, 0); push_beat(64'h44, 64'h4, 4'd2, 1);
    run_burst(64'h8000_0040, 3, 4'd2, 2, 0);
    chk("full_line_data", line_data_o, {64'h44, 64'h33, 64'h22, 64'h11});
    chk("full_line_err", line_err_o, 1'b0);
    chk("full_line_req_ready", req_ready_o, 1'b0);
    consume(1);

    // Single beat refreshes word 0 only.
    clear_beats();
    push_beat(64'hDEAD, 64'h5, 4'd1, 1);
    run_burst(64'h100, 0, 4'd1, 0, 0);
    chk("single_data", line_data_o, {64'h44, 64'h33, 64'h22, 64'hDEAD});
    chk("single_err", line_err_o, 1'b0);
    consume(0);

    // Early last.
    clear_beats();
    push_beat(64'hA1, 64'h6, 4'd3, 0); push_beat(64'hA2, 64'h7, 4'd3, 1);
    run_burst(64'h200, 3, 4'd3, 1, 0);
    chk("early_last_data", line_data_o, {64'h44, 64'h33, 64'hA2, 64'hA1});
    chk("early_last_err", line_err_o, 1'b1);
    consume(2);

    // Overlong burst: third beat dropped.
    clear_beats();
    push_beat(64'hB1, 64'h8, 4'd4, 0); push_beat(64'hB2, 64'h9, 4'd4, 0); push_beat(64'hB3, 64'hA, 4'd4, 1);
    run_burst(64'h300, 1, 4'd4, 0, 0);
    chk("overlong_data", line_data_o, {64'h44, 64'h33, 64'hB2, 64'hB1});
    chk("overlong_err", line_err_o, 1'b1);
    consume(0);

    // Foreign-ID beat inside the burst.
    clear_beats();
    push_beat(64'hC1, 64'hB, 4'd2, 0); push_beat(64'h99, 64'hC, 4'd5, 0);
    push_beat(64'hC2, 64'hD, 4'd2, 0); push_beat(64'hC3, 64'hE, 4'd2, 0); push_beat(64'hC4, 64'hF, 4'd2, 1);
    run_burst(64'h400, 3, 4'd2, 0, 0);
    if (IdCheck) chk("id_mix_data", line_data_o, {64'hC4, 64'hC3, 64'hC2, 64'hC1});
    else         chk("id_mix_data", line_data_o, {64'hC3, 64'hC2, 64'h99, 64'hC1});
    chk("id_mix_err", line_err_o, 1'b1);
    consume(0);

    // Reset in the middle of a burst, then stray beats.
    clear_beats();
    push_beat(64'hE1, 64'h1, 4'd6, 0); push_beat(64'hE2, 64'h2, 4'd6, 0);
    push_beat(64'hE3, 64'h3, 4'd6, 0); push_beat(64'hE4, 64'h4, 4'd6, 1);
    start_req(64'h500, 3, 4'd6, 0);
    wait_sig(2, "rd_rdy");
    send_beat(0, 0);
    send_beat(1, 0);
    rst_ni = 1'b0;
    model_reset();
    tick();
    rst_ni = 1'b1;
    send_beat(2, 0);
    send_beat(3, 0);
    tick();
    chk("abort_rd_rdy", rd_rdy_o, 1'b0);
    chk("abort_line_valid", line_valid_o, 1'b0);
    chk("abort_req_ready", req_ready_o, 1'b1);
    chk("abort_line_data", line_data_o, '0);

    // Randomized bursts: short, exact and overlong, with gaps and (under ID checking) foreign beats.
    for (int t = 0; t < 40; t++) begin
      int blen = $urandom_range(0, N - 1);
      int nb   = $urandom_range(1, N + 2);
      logic [IW-1:0] id = IW'($urandom);
      clear_beats();
      for (int k = 0; k < nb; k++) begin
        if (IdCheck && $urandom_range(0, 3) == 0)
          push_beat({$urandom, $urandom}, {$urandom, $urandom}, id ^ IW'($urandom_range(1, 15)),
                    bit'($urandom_range(0, 1)));
        push_beat({$urandom, $urandom}, {$urandom, $urandom}, IdCheck ? id : IW'($urandom), k == nb - 1);
      end
      run_burst({$urandom, $urandom}, blen, id, $urandom_range(0, 3), 1);
      consume($urandom_range(0, 2));
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
